// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings, FSM state type and size helper for the MEM-stage RAM sequencer.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StDone
  } state_e;

  // Illegal size maps to 1 so bounds arithmetic stays sane; it faults anyway.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response and RAM strobe signals of mem_access_ctrl.
interface mem_access_ctrl_if;

  logic        req;
  logic        rw;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_size;
  logic [31:0] mem_dout;

  // Master is the surrounding system: MEM stage plus the RAM itself.
  modport master (
    output req, rw, size, sign_ext, addr, wdata, mem_dout,
    input  ready, done, err, rdata, mem_en, mem_rw, mem_addr, mem_din, mem_size
  );

  modport slave (
    input  req, rw, size, sign_ext, addr, wdata, mem_dout,
    output ready, done, err, rdata, mem_en, mem_rw, mem_addr, mem_din, mem_size
  );

endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational zero/sign extension of byte and half-word RAM reads.
module mem_load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_mem_dout,
  output logic [31:0] o_ext
);

  always_comb begin
    o_ext = i_mem_dout;
    case (i_size)
      SZ_BYTE: o_ext = {{24{i_sign_ext & i_mem_dout[7]}}, i_mem_dout[7:0]};
      SZ_HALF: o_ext = {{16{i_sign_ext & i_mem_dout[15]}}, i_mem_dout[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for the byte-write data RAM: setup-then-strobe, big-endian byte stores.
// Define MEM_CTRL_ALIGN_CHECK_EN to fault misaligned half-word and word accesses.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  mem_access_ctrl_if.slave io_bus
);

  localparam logic [32:0] DepthW = 33'(MEM_DEPTH);

  state_e      r_state, w_state_d;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [1:0]  r_size, r_cnt;
  logic        r_rw, r_sext, r_err;

  logic        w_accept, w_fault, w_misalign, w_oob, w_last_byte;
  logic [2:0]  w_req_nbytes, w_nbytes;
  logic [32:0] w_end;
  logic [1:0]  w_sel;
  logic [31:0] w_ext;

  assign w_accept     = (r_state == StIdle) && io_bus.req;
  assign w_req_nbytes = size_nbytes(io_bus.size);
  assign w_end        = {1'b0, io_bus.addr} + 33'(w_req_nbytes) - 33'd1;
  assign w_oob        = ({1'b0, io_bus.addr} >= DepthW) || (w_end >= DepthW);

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign w_misalign = ((io_bus.size == SZ_HALF) && io_bus.addr[0]) ||
                      ((io_bus.size == SZ_WORD) && (io_bus.addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault = (io_bus.size == 2'b11) || w_oob || w_misalign;

  // Loads take a single strobe; stores walk the byte counter to nbytes-1.
  assign w_nbytes    = size_nbytes(r_size);
  assign w_last_byte = (r_rw == OP_LOAD) || (r_cnt == 2'(w_nbytes - 3'd1));
  assign w_sel       = 2'(w_nbytes - 3'd1) - r_cnt;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (io_bus.req) w_state_d = w_fault ? StDone : StSetup;
      StSetup:  w_state_d = StStrobe;
      StStrobe: w_state_d = w_last_byte ? StDone : StSetup;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= SZ_BYTE;
      r_rw    <= OP_LOAD;
      r_sext  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= io_bus.addr;
        r_wdata <= io_bus.wdata;
        r_size  <= io_bus.size;
        r_rw    <= io_bus.rw;
        r_sext  <= io_bus.sign_ext;
        r_err   <= w_fault;
        r_cnt   <= '0;
      end else if ((r_state == StStrobe) && !w_last_byte) begin
        r_cnt <= r_cnt + 2'd1;
      end
      if ((r_state == StStrobe) && (r_rw == OP_LOAD)) begin
        r_rdata <= w_ext;
      end
    end
  end

  mem_load_extend u_load_extend (
    .i_size     (r_size),
    .i_sign_ext (r_sext),
    .i_mem_dout (io_bus.mem_dout),
    .o_ext      (w_ext)
  );

  // RAM-side fields derive from latched request state, so they are stable across SETUP and STROBE.
  assign io_bus.ready    = (r_state == StIdle);
  assign io_bus.done     = (r_state == StDone);
  assign io_bus.err      = r_err;
  assign io_bus.rdata    = r_rdata;
  assign io_bus.mem_en   = (r_state == StStrobe);
  assign io_bus.mem_rw   = r_rw;
  assign io_bus.mem_addr = r_addr + {30'b0, r_cnt};
  assign io_bus.mem_size = (r_rw == OP_STORE) ? SZ_BYTE : r_size;
  assign io_bus.mem_din  = (r_rw == OP_STORE) ? {24'b0, r_wdata[{w_sel, 3'b000} +: 8]} : 32'b0;

endmodule
